mm_seq_ctrl: RTL and testbench
==============================

# mm_seq_ctrl

Control FSM for the matrix-multiply engine. It fetches the three-word dimension header from the shared operand memory and walks the (row, column, k) loop nest, emitting the read/write/index/i/j memory protocol. It drives the MAC datapath's load, accumulate and clear strobes, then raises finish. It contains no arithmetic on matrix data: the datapath captures read_data and forms the 2N-bit signed sum.

## Interface
- N, 20, width of data words, dimension registers, loop counters and i/j

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level/pulse; sampled only in IDLE or DONE
- read_data  in  N  memory return word; valid at the rising edge that ends the request cycle
- read  out  1  memory read request
- write  out  1  memory write strobe; read and write both high = header fetch
- index  out  1  0 = matrix A, 1 = matrix B (meaningful when only read is high)
- i  out  N  row index (header word number during header fetch)
- j  out  N  column index
- a_ld  out  1  datapath: capture read_data as A operand at end of cycle
- mac_en  out  1  datapath: acc += A * read_data at end of cycle
- acc_clr  out  1  datapath: clear accumulator at end of cycle (after write_data is consumed)
- busy  out  1  high in every state except IDLE and DONE
- finish  out  1  level; high in DONE
- err  out  1  high in DONE when the header contained a zero dimension

## Operation
- All outputs are registered. Reset value of every output is 0; state = IDLE; dimension registers and counters = 0.
- **IDLE:** outputs 0. start=1 → HDR0.
- **HDR0/HDR1/HDR2:**
  - read=write=1, i=0/1/2, j=0.
  - read_data captured at the ending edge into row1, col1, col2 respectively.
- **CHK:**
  - One cycle, no memory request.
  - If any of row1/col1/col2 is 0: err←1 → DONE.
  - Otherwise r=c=k=0 and acc_clr=1 → RDA.
- **RDA:** read=1, index=0, i=r, j=k, a_ld=1 → RDB.
- **RDB:**
  - read=1, index=1, i=k, j=c, mac_en=1.
  - If k==col1-1: k←0 → WR.
  - Otherwise k←k+1 → RDA.
- **WR:**
  - write=1, read=0, i=r, j=c, acc_clr=1.
  - If c<col2-1: c←c+1.
  - Else c←0 and r←r+1.
  - If this was the last element (r==row1-1, c==col2-1) → DONE; otherwise → RDA.
- **DONE:**
  - finish=1; err holds.
  - start=1 clears finish and err and goes to HDR0, i.e. a new job is accepted directly from DONE.
- Outputs are written in row-major order, one WR cycle per C element, row1*col2 writes total.
- start while busy is ignored; there is no abort other than reset.
- Loop counters compare against captured dimensions only. Counters never wrap, since dimensions are bounded by N.
- **reset asserted mid-operation:**
  - Immediate return to IDLE with all outputs 0 (asynchronous).
  - No partial write completes after reset assertion.
  - Deassertion takes effect at the next rising edge.

## Timing
- Memory latency: exactly 1 cycle. The request is presented during cycle t and read_data is sampled at the edge ending cycle t.
- **Timeline:** start sampled at edge 0 → HDR0 in cycle 1, HDR2 in cycle 3, CHK in cycle 4, first RDA in cycle 5.
- **Per output element:** 2*col1+1 cycles.
- **Total from start edge to finish high:** 4 + row1*col2*(2*col1+1) cycles, then finish rises on the next cycle.
- **Zero dimension:** finish and err rise in cycle 5, with no read/index-only or write-only cycles issued.
- read and write are never both high outside HDR0–HDR2. a_ld, mac_en and acc_clr are mutually exclusive except acc_clr in CHK.

## Test plan
- **Basic run:** header 2,3,2 → 3 header cycles, then 4 groups of (6 reads alternating index 0/1, 1 write).
  - Write order (i,j) = (0,0),(0,1),(1,0),(1,1).
  - finish high in cycle 33.
  - Datapath result must match a 40-bit signed reference.
- **col1=1:** header 3,1,3 → each element takes 3 cycles (RDA, RDB, WR); 9 writes; finish high in cycle 32.
- **Zero dimension:** header 0,4,5 → err=1 and finish=1 in cycle 5; no write-only cycle ever asserted.
- **Reset mid-run:** reset low during the 2nd RDB of the basic run.
  - All outputs 0 immediately.
  - After release, IDLE with no writes until start.
  - Re-run completes correctly.
- **Back-to-back jobs:** start held in DONE → finish and err cleared, HDR0 next cycle.
  - start pulsed while busy → no effect on sequence or cycle count.
- **Signed extremes:** 1x1 times 1x1 with A=-2^19, B=-2^19 → one write of +2^38 on the 40-bit write_data; acc cleared before the next job.

Source files
------------

// File: rtl/mm_seq_ctrl.sv
// Sequencer for the matrix-multiply engine: fetches the dimension header, walks the
// (row, column, k) loop nest and drives the memory protocol and MAC datapath strobes.
module mm_seq_ctrl #(
  parameter int unsigned N = 20
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         start_i,
  input  logic [N-1:0] read_data_i,
  output logic         read_o,
  output logic         write_o,
  output logic         index_o,
  output logic [N-1:0] i_o,
  output logic [N-1:0] j_o,
  output logic         a_ld_o,
  output logic         mac_en_o,
  output logic         acc_clr_o,
  output logic         busy_o,
  output logic         finish_o,
  output logic         err_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_CHK,
    S_RDA,
    S_RDB,
    S_WR,
    S_DONE
  } state_e;

  typedef struct packed {
    logic         read;
    logic         write;
    logic         index;
    logic [N-1:0] i;
    logic [N-1:0] j;
    logic         a_ld;
    logic         mac_en;
    logic         acc_clr;
    logic         busy;
    logic         finish;
    logic         err;
  } out_t;

  state_e       state_q, state_d;
  logic [N-1:0] row1_q, row1_d;
  logic [N-1:0] col1_q, col1_d;
  logic [N-1:0] col2_q, col2_d;
  logic [N-1:0] r_q, r_d;
  logic [N-1:0] c_q, c_d;
  logic [N-1:0] k_q, k_d;
  logic         err_d;
  out_t         out_q, out_d;

  // State, captured dimensions, loop counters and the registered output bundle
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      row1_q  <= '0;
      col1_q  <= '0;
      col2_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      row1_q  <= row1_d;
      col1_q  <= col1_d;
      col2_q  <= col2_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      out_q   <= out_d;
    end
  end

  // Next state plus outputs decoded from the state being entered, so they are
  // registered yet line up with the cycle the state occupies
  always_comb begin
    state_d = state_q;
    row1_d  = row1_q;
    col1_d  = col1_q;
    col2_d  = col2_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    err_d   = out_q.err;
    out_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          err_d   = 1'b0;
          state_d = S_HDR0;
        end
      end
      S_HDR0: begin
        row1_d  = read_data_i;
        state_d = S_HDR1;
      end
      S_HDR1: begin
        col1_d  = read_data_i;
        state_d = S_HDR2;
      end
      S_HDR2: begin
        col2_d  = read_data_i;
        state_d = S_CHK;
      end
      S_CHK: begin
        if ((row1_q == '0) || (col1_q == '0) || (col2_q == '0)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
          state_d = S_RDA;
        end
      end
      S_RDA: begin
        state_d = S_RDB;
      end
      S_RDB: begin
        if (k_q == col1_q - N'(1)) begin
          k_d     = '0;
          state_d = S_WR;
        end else begin
          k_d     = k_q + N'(1);
          state_d = S_RDA;
        end
      end
      S_WR: begin
        if (c_q < col2_q - N'(1)) begin
          c_d = c_q + N'(1);
        end else begin
          c_d = '0;
          r_d = r_q + N'(1);
        end
        if ((r_q == row1_q - N'(1)) && (c_q == col2_q - N'(1))) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RDA;
        end
      end
      S_DONE: begin
        if (start_i) begin
          err_d   = 1'b0;
          state_d = S_HDR0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    unique case (state_d)
      S_HDR0, S_HDR1, S_HDR2: begin
        out_d.read  = 1'b1;
        out_d.write = 1'b1;
        out_d.busy  = 1'b1;
        if (state_d == S_HDR1) out_d.i = N'(1);
        if (state_d == S_HDR2) out_d.i = N'(2);
      end
      S_CHK: begin
        out_d.acc_clr = 1'b1;
        out_d.busy    = 1'b1;
      end
      S_RDA: begin
        out_d.read = 1'b1;
        out_d.i    = r_d;
        out_d.j    = k_d;
        out_d.a_ld = 1'b1;
        out_d.busy = 1'b1;
      end
      S_RDB: begin
        out_d.read   = 1'b1;
        out_d.index  = 1'b1;
        out_d.i      = k_d;
        out_d.j      = c_d;
        out_d.mac_en = 1'b1;
        out_d.busy   = 1'b1;
      end
      S_WR: begin
        out_d.write   = 1'b1;
        out_d.i       = r_d;
        out_d.j       = c_d;
        out_d.acc_clr = 1'b1;
        out_d.busy    = 1'b1;
      end
      S_DONE: begin
        out_d.finish = 1'b1;
        out_d.err    = err_d;
      end
      default: begin
        out_d = '0;
      end
    endcase
  end

  assign read_o    = out_q.read;
  assign write_o   = out_q.write;
  assign index_o   = out_q.index;
  assign i_o       = out_q.i;
  assign j_o       = out_q.j;
  assign a_ld_o    = out_q.a_ld;
  assign mac_en_o  = out_q.mac_en;
  assign acc_clr_o = out_q.acc_clr;
  assign busy_o    = out_q.busy;
  assign finish_o  = out_q.finish;
  assign err_o     = out_q.err;

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Bench for mm_seq_ctrl: behavioural memory and MAC datapath around the sequencer,
// with expected protocol and results derived from the matrix product directly.
module tb_mm_seq_ctrl;

  localparam int unsigned N  = 20;
  localparam int unsigned MD = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] rd_data;
  logic         read_o, write_o, index_o;
  logic [N-1:0] i_o, j_o;
  logic         a_ld_o, mac_en_o, acc_clr_o, busy_o, finish_o, err_o;

  logic [N-1:0] hdr_m [0:3];
  logic [N-1:0] a_m   [0:MD-1][0:MD-1];
  logic [N-1:0] b_m   [0:MD-1][0:MD-1];

  logic signed [N-1:0]  opa_m;
  logic signed [39:0]   acc_m;
  logic signed [39:0]   last_wr_v;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  mm_seq_ctrl dut (
    .clk_i       (clk),
    .reset_ni    (rst_n),
    .start_i     (start),
    .read_data_i (rd_data),
    .read_o      (read_o),
    .write_o     (write_o),
    .index_o     (index_o),
    .i_o         (i_o),
    .j_o         (j_o),
    .a_ld_o      (a_ld_o),
    .mac_en_o    (mac_en_o),
    .acc_clr_o   (acc_clr_o),
    .busy_o      (busy_o),
    .finish_o    (finish_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory: header, A and B selected by read/write/index
  always_comb begin
    rd_data = '0;
    if (read_o && write_o) begin
      if (i_o < N'(3)) rd_data = hdr_m[i_o[1:0]];
    end else if (read_o && (i_o < N'(MD)) && (j_o < N'(MD))) begin
      rd_data = index_o ? b_m[i_o[2:0]][j_o[2:0]] : a_m[i_o[2:0]][j_o[2:0]];
    end
  end

  // External MAC datapath driven by the sequencer strobes
  always @(posedge clk) begin
    if (a_ld_o) opa_m <= $signed(rd_data);
    if (acc_clr_o) acc_m <= '0;
    else if (mac_en_o) acc_m <= acc_m + (40'(opa_m) * 40'($signed(rd_data)));
  end

  task automatic fill_random(input int r1, input int c1, input int c2, input int mag);
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        a_m[r][c] = N'($urandom_range(0, mag) - mag / 2);
        b_m[r][c] = N'($urandom_range(0, mag) - mag / 2);
      end
    if (r1 < 0 || c1 < 0 || c2 < 0) $display("bad dims");
  endtask

  task automatic run_job(input string name, input int r1, input int c1, input int c2,
                         input int pulse_cyc, output int fin_cyc, output int wr_cnt);
    bit zero;
    int exp_fin, exp_rd;
    int er_i[$], er_j[$], ew_i[$], ew_j[$];
    bit er_x[$];
    logic signed [39:0] ew_v[$];
    longint s;
    int cyc, rd_n, wr_n, hdr_bad, proto, rd_bad, wr_bad;
    bit c1_ok, done_ok;

    zero    = (r1 == 0) || (c1 == 0) || (c2 == 0);
    exp_fin = zero ? 5 : 5 + r1 * c2 * (2 * c1 + 1);
    hdr_m[0] = N'(r1);
    hdr_m[1] = N'(c1);
    hdr_m[2] = N'(c2);
    hdr_m[3] = '0;
    if (!zero) begin
      for (int r = 0; r < r1; r++)
        for (int c = 0; c < c2; c++) begin
          s = 0;
          for (int k = 0; k < c1; k++) begin
            er_x.push_back(1'b0); er_i.push_back(r); er_j.push_back(k);
            er_x.push_back(1'b1); er_i.push_back(k); er_j.push_back(c);
            s += longint'($signed(a_m[r][k])) * longint'($signed(b_m[k][c]));
          end
          ew_i.push_back(r); ew_j.push_back(c); ew_v.push_back(40'(s));
        end
    end
    exp_rd = er_x.size();

    cyc = 0; fin_cyc = 0; rd_n = 0; wr_n = 0;
    hdr_bad = 0; proto = 0; rd_bad = 0; wr_bad = 0; c1_ok = 0; done_ok = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (fin_cyc == 0 && cyc < exp_fin + 20) begin
      @(negedge clk);
      cyc++;
      start = (cyc == pulse_cyc);
      if (cyc == 1) c1_ok = !finish_o && !err_o && read_o && write_o && (i_o == '0);
      if (cyc <= 3) begin
        if (!(read_o && write_o && (i_o == N'(cyc - 1)) && (j_o == '0) && busy_o)) hdr_bad++;
      end else if (finish_o) begin
        fin_cyc = cyc;
        done_ok = !read_o && !write_o && !busy_o && !a_ld_o && !mac_en_o && !acc_clr_o;
      end else begin
        if (read_o && write_o) proto++;
        if (!busy_o) proto++;
        if (int'(a_ld_o) + int'(mac_en_o) + int'(acc_clr_o) > 1) proto++;
        if (read_o && !write_o) begin
          if (rd_n >= exp_rd || index_o !== er_x[rd_n] || i_o !== N'(er_i[rd_n])
              || j_o !== N'(er_j[rd_n])) rd_bad++;
          rd_n++;
        end
        if (write_o && !read_o) begin
          if (wr_n >= ew_i.size() || i_o !== N'(ew_i[wr_n]) || j_o !== N'(ew_j[wr_n])
              || acc_m !== ew_v[wr_n]) wr_bad++;
          last_wr_v = acc_m;
          wr_n++;
        end
      end
    end
    start  = 1'b0;
    wr_cnt = wr_n;

    chk_cnt++;
    if (fin_cyc !== exp_fin) $display("FAIL %s finish_cycle got %0d want %0d", name, fin_cyc, exp_fin);
    else pass_cnt++;
    chk_cnt++;
    if (err_o !== zero) $display("FAIL %s err got %b want %b", name, err_o, zero);
    else pass_cnt++;
    chk_cnt++;
    if (c1_ok !== 1'b1) $display("FAIL %s cycle1_hdr0_clear got %b want 1", name, c1_ok);
    else pass_cnt++;
    chk_cnt++;
    if (hdr_bad !== 0) $display("FAIL %s header_cycles bad=%0d want 0", name, hdr_bad);
    else pass_cnt++;
    chk_cnt++;
    if (proto !== 0) $display("FAIL %s protocol violations=%0d want 0", name, proto);
    else pass_cnt++;
    chk_cnt++;
    if (rd_bad !== 0 || rd_n !== exp_rd)
      $display("FAIL %s reads got %0d (bad %0d) want %0d", name, rd_n, rd_bad, exp_rd);
    else pass_cnt++;
    chk_cnt++;
    if (wr_bad !== 0 || wr_n !== ew_i.size())
      $display("FAIL %s writes got %0d (bad %0d) want %0d", name, wr_n, wr_bad, ew_i.size());
    else pass_cnt++;
    chk_cnt++;
    if (done_ok !== 1'b1) $display("FAIL %s done_outputs got %b want 1", name, done_ok);
    else pass_cnt++;
    if (!zero) begin
      chk_cnt++;
      if (acc_m !== 40'sd0) $display("FAIL %s acc_after_job got %0d want 0", name, acc_m);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({read_o, write_o, index_o, i_o, j_o, a_ld_o, mac_en_o, acc_clr_o, busy_o, finish_o, err_o} !== '0)
      $display("FAIL reset_outputs got nonzero want 0");
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_cnt++;
    if ({read_o, write_o, busy_o, finish_o, err_o} !== 5'b0)
      $display("FAIL idle_after_reset got %b want 00000", {read_o, write_o, busy_o, finish_o, err_o});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int fin, wr;
    fill_random(2, 3, 2, 2000);
    run_job("basic", 2, 3, 2, 0, fin, wr);
    chk_cnt++;
    if (fin !== 33 || wr !== 4) $display("FAIL basic_timeline finish %0d writes %0d want 33 4", fin, wr);
    else pass_cnt++;
  endtask

  task automatic test_col1();
    int fin, wr;
    fill_random(3, 1, 3, 1 << 19);
    run_job("col1", 3, 1, 3, 0, fin, wr);
    chk_cnt++;
    if (fin !== 32 || wr !== 9) $display("FAIL col1_timeline finish %0d writes %0d want 32 9", fin, wr);
    else pass_cnt++;
  endtask

  task automatic test_zero_dim();
    int fin, wr;
    run_job("zero_dim", 0, 4, 5, 0, fin, wr);
    chk_cnt++;
    if (fin !== 5 || wr !== 0 || err_o !== 1'b1)
      $display("FAIL zero_dim finish %0d writes %0d err %b want 5 0 1", fin, wr, err_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int fin, wr;
    run_job("b2b_zero", 4, 0, 2, 2, fin, wr);
    fill_random(2, 2, 3, 1 << 20);
    run_job("b2b_from_done", 2, 2, 3, 9, fin, wr);
    chk_cnt++;
    if (fin !== 5 + 2 * 3 * 5) $display("FAIL b2b_pulse_timeline finish %0d want %0d", fin, 35);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int fin, wr;
    fill_random(2, 3, 2, 4000);
    hdr_m[0] = N'(2); hdr_m[1] = N'(3); hdr_m[2] = N'(2);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    chk_cnt++;
    if ({read_o, index_o, mac_en_o} !== 3'b111)
      $display("FAIL reset_mid_in_rdb got %b want 111", {read_o, index_o, mac_en_o});
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({read_o, write_o, index_o, i_o, j_o, a_ld_o, mac_en_o, acc_clr_o, busy_o, finish_o, err_o} !== '0)
      $display("FAIL reset_mid_outputs got nonzero want 0");
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    wr = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (read_o || write_o || busy_o || finish_o) wr++;
    end
    chk_cnt++;
    if (wr !== 0) $display("FAIL reset_mid_idle active cycles %0d want 0", wr);
    else pass_cnt++;
    run_job("rerun_after_reset", 2, 3, 2, 0, fin, wr);
  endtask

  task automatic test_signed_extremes();
    int fin, wr;
    a_m[0][0] = 20'h80000;
    b_m[0][0] = 20'h80000;
    run_job("signed_ext", 1, 1, 1, 0, fin, wr);
    chk_cnt++;
    if (last_wr_v !== 40'sh40_0000_0000 || wr !== 1)
      $display("FAIL signed_ext write_data got %0d (writes %0d) want 274877906944", last_wr_v, wr);
    else pass_cnt++;
    fill_random(1, 2, 1, 100);
    run_job("after_ext", 1, 2, 1, 0, fin, wr);
  endtask

  task automatic test_random();
    int fin, wr, r1, c1, c2, ef, p;
    for (int t = 0; t < 8; t++) begin
      r1 = $urandom_range(0, 4);
      c1 = $urandom_range(1, 4);
      c2 = $urandom_range(1, 4);
      if (t == 3) c1 = 0;
      fill_random(r1, c1, c2, 1 << 20);
      ef = ((r1 == 0) || (c1 == 0)) ? 5 : 5 + r1 * c2 * (2 * c1 + 1);
      p  = (t % 2 == 0) ? int'($urandom_range(1, ef - 2)) : 0;
      run_job($sformatf("random%0d", t), r1, c1, c2, p, fin, wr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_col1();
    test_zero_dim();
    test_back_to_back();
    test_reset_mid();
    test_signed_extremes();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
